// File: rtl/constant_bank.sv
// ---------------------------------------------------------------------------
// constant_bank
//
// Parametrised constant-tie generator. Drives NCH registered constant lines
// plus fixed one/zero ties. Every programmable line sits at DEFAULT_VAL from
// reset until a settle interval of RELEASE_CYCLES clock edges has elapsed.
// After release, firmware rewrites lines with a masked valid/ready write.
// A sticky lock then freezes the lines until the next reset.
//
// Ports:
//   clk        block clock
//   resetb     asynchronous active-low reset
//   wr_valid   write request
//   wr_ready   write accept, high only while ACTIVE (decoded from state only)
//   wr_data    new channel values               [NCH]
//   wr_mask    per-bit write enable, 1 = update [NCH]
//   lock       lock request, honoured in ACTIVE only
//   released   settle interval complete (registered)
//   locked     sticky lock status (registered)
//   const_out  registered constant lines        [NCH]
//   one/zero   pure ties, valid during reset
// ---------------------------------------------------------------------------

// One registered constant channel. Each bit lives in its own flop with its
// own reset value, so a line only ever moves on a clock edge or on reset.
module constant_bank_lane #(
    parameter logic DEF_BIT = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic we,
    input  logic wd,
    output logic q
);
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            q <= DEF_BIT;
        else if (we)
            q <= wd;
    end
endmodule

module constant_bank #(
    parameter int                 NCH            = 8,
    parameter logic [NCH-1:0]     DEFAULT_VAL    = {NCH{1'b0}},
    parameter int                 RELEASE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           resetb,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [NCH-1:0] wr_data,
    input  logic [NCH-1:0] wr_mask,
    input  logic           lock,
    output logic           released,
    output logic           locked,
    output logic [NCH-1:0] const_out,
    output logic           one,
    output logic           zero
);
    localparam int             CW       = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(RELEASE_CYCLES);

    // Encoding chosen so released = state[0] and locked = state[1] come
    // straight off flops: no decode glitches on the status outputs.
    typedef enum logic [1:0] {
        S_HOLD   = 2'b00,
        S_ACTIVE = 2'b01,
        S_LOCKED = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          wr_fire;

    // -----------------------------------------------------------------------
    // Ties: no dependence on clock, reset or state.
    // -----------------------------------------------------------------------
    assign one  = 1'b1;
    assign zero = 1'b0;

    // -----------------------------------------------------------------------
    // State and settle counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= S_HOLD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_HOLD: begin
                // Counter saturates at RELEASE_CYCLES; the edge that brings
                // it there is the release edge.
                if (cnt != CNT_LAST)
                    cnt_nxt = cnt + 1'b1;
                if (cnt_nxt == CNT_LAST)
                    state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (lock)
                    state_nxt = S_LOCKED;
            end
            S_LOCKED: begin
                state_nxt = S_LOCKED;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: functions of the state register only, no input paths.
    // -----------------------------------------------------------------------
    always_comb begin
        released = state[0];
        locked   = state[1];
        wr_ready = state[0] & ~state[1];
    end

    // A write issued together with lock still lands: the lock only takes
    // effect from the following cycle, when wr_ready has dropped.
    assign wr_fire = wr_valid & wr_ready;

    // -----------------------------------------------------------------------
    // Channel storage
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_lane
        constant_bank_lane #(
            .DEF_BIT (DEFAULT_VAL[g])
        ) u_lane (
            .clk    (clk),
            .resetb (resetb),
            .we     (wr_fire & wr_mask[g]),
            .wd     (wr_data[g]),
            .q      (const_out[g])
        );
    end

endmodule

// File: tb/tb_constant_bank.sv
// ---------------------------------------------------------------------------
// tb_constant_bank
//
// Three instances share clock and reset:
//   u8  : NCH=8,  DEFAULT_VAL=8'hA5,        RELEASE_CYCLES=16
//   u1  : NCH=1,  DEFAULT_VAL=1'b1,         RELEASE_CYCLES=1
//   u32 : NCH=32, DEFAULT_VAL=32'h12345678, RELEASE_CYCLES=4
// A behavioural model (a few flags plus masked-merge arithmetic) is stepped
// once per edge and compared against every instance every cycle. Directed
// vectors and hand sequences add explicit expectations on top.
// ---------------------------------------------------------------------------
module tb_constant_bank;

    logic clk;
    logic resetb;

    logic        wv [3];
    logic [31:0] wd [3];
    logic [31:0] wm [3];
    logic        lk [3];

    logic [2:0]  rdy, rel, lck, one_o, zero_o;
    logic [7:0]  out8;
    logic [0:0]  out1;
    logic [31:0] out32;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    localparam logic [31:0] DEF [3] = '{32'hA5, 32'h1, 32'h12345678};
    localparam int          RC  [3] = '{16, 1, 4};
    localparam logic [31:0] WID [3] = '{32'hFF, 32'h1, 32'hFFFF_FFFF};
    logic [31:0] m_out [3];
    int          m_cnt [3];
    bit          m_rel [3];
    bit          m_lck [3];

    constant_bank #(.NCH(8), .DEFAULT_VAL(8'hA5), .RELEASE_CYCLES(16)) u8 (
        .clk(clk), .resetb(resetb), .wr_valid(wv[0]), .wr_ready(rdy[0]),
        .wr_data(wd[0][7:0]), .wr_mask(wm[0][7:0]), .lock(lk[0]),
        .released(rel[0]), .locked(lck[0]), .const_out(out8),
        .one(one_o[0]), .zero(zero_o[0]));

    constant_bank #(.NCH(1), .DEFAULT_VAL(1'b1), .RELEASE_CYCLES(1)) u1 (
        .clk(clk), .resetb(resetb), .wr_valid(wv[1]), .wr_ready(rdy[1]),
        .wr_data(wd[1][0:0]), .wr_mask(wm[1][0:0]), .lock(lk[1]),
        .released(rel[1]), .locked(lck[1]), .const_out(out1),
        .one(one_o[1]), .zero(zero_o[1]));

    constant_bank #(.NCH(32), .DEFAULT_VAL(32'h12345678), .RELEASE_CYCLES(4)) u32 (
        .clk(clk), .resetb(resetb), .wr_valid(wv[2]), .wr_ready(rdy[2]),
        .wr_data(wd[2]), .wr_mask(wm[2]), .lock(lk[2]),
        .released(rel[2]), .locked(lck[2]), .const_out(out32),
        .one(one_o[2]), .zero(zero_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dout(int i);
        case (i)
            0:       return {24'h0, out8};
            1:       return {31'h0, out1};
            default: return out32;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_out[i] = DEF[i];
            m_cnt[i] = 0;
            m_rel[i] = 0;
            m_lck[i] = 0;
        end
    endtask

    // One rising edge of the behavioural model, using the currently driven inputs.
    task automatic model_tick();
        for (int i = 0; i < 3; i++) begin
            if (!m_rel[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == RC[i]) m_rel[i] = 1;
            end else if (!m_lck[i]) begin
                if (wv[i])
                    m_out[i] = ((m_out[i] & ~wm[i]) | (wd[i] & wm[i])) & WID[i];
                if (lk[i]) m_lck[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d const_out", i), dout(i), m_out[i]);
            chk($sformatf("dut%0d released", i), 32'(rel[i]), 32'(m_rel[i]));
            chk($sformatf("dut%0d locked", i), 32'(lck[i]), 32'(m_lck[i]));
            chk($sformatf("dut%0d wr_ready", i), 32'(rdy[i]), 32'(m_rel[i] && !m_lck[i]));
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            wv[i] = 0; wd[i] = '0; wm[i] = '0; lk[i] = 0;
        end
    endtask

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic [7:0] wm;
        logic       lk;
        logic [7:0] exp_out;
        logic       exp_rdy;
        logic       exp_lck;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 8'h0F, 8'h3C, 1'b0, 8'h8D, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h8D, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h01, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h02, 8'hFF, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h03, 8'hFF, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'hEE, 8'hFF, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h55, 8'hFF, 1'b1, 8'h55, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 8'hAA, 8'hFF, 1'b1, 8'h55, 1'b0, 1'b1};

        idle_all();
        resetb = 1'b0;
        model_reset();

        // --- during reset ---
        repeat (3) @(posedge clk);
        #1;
        chk("rst out8", {24'h0, out8}, 32'hA5);
        chk("rst out32", out32, 32'h12345678);
        chk("rst one", 32'(one_o), 32'h7);
        chk("rst zero", 32'(zero_o), 32'h0);
        check_all();

        // --- release; dut8 sees a write attempt throughout HOLD ---
        @(negedge clk);
        resetb = 1'b1;
        wv[0] = 1; wd[0] = 32'hFF; wm[0] = 32'hFF;
        for (int e = 1; e <= 16; e++) begin
            step();
            chk($sformatf("hold rel8 e%0d", e), 32'(rel[0]), (e >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("hold rdy8 e%0d", e), 32'(rdy[0]), (e >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("hold out8 e%0d", e), {24'h0, out8}, 32'hA5);
            if (e == 1) chk("rel1 first edge", 32'(rel[1]), 32'd1);
        end
        idle_all();

        // --- parameter corners: 1-bit masked writes, 32-bit full write ---
        wv[1] = 1; wd[1] = 0; wm[1] = 1;
        wv[2] = 1; wd[2] = 32'hDEADBEEF; wm[2] = 32'hFFFF_FFFF;
        step();
        chk("nch1 write0", {31'h0, out1}, 32'h0);
        chk("nch32 readback", out32, 32'hDEADBEEF);
        wv[1] = 1; wd[1] = 1; wm[1] = 0;
        wv[2] = 0;
        step();
        chk("nch1 mask0 hold", {31'h0, out1}, 32'h0);
        wv[1] = 1; wd[1] = 1; wm[1] = 1;
        step();
        chk("nch1 write1", {31'h0, out1}, 32'h1);
        idle_all();

        // --- directed vectors on dut8 ---
        for (int v = 0; v < 9; v++) begin
            wv[0] = vecs[v].wv; wd[0] = {24'h0, vecs[v].wd};
            wm[0] = {24'h0, vecs[v].wm}; lk[0] = vecs[v].lk;
            step();
            chk($sformatf("vec%0d out", v), {24'h0, out8}, {24'h0, vecs[v].exp_out});
            chk($sformatf("vec%0d rdy", v), 32'(rdy[0]), 32'(vecs[v].exp_rdy));
            chk($sformatf("vec%0d lck", v), 32'(lck[0]), 32'(vecs[v].exp_lck));
        end

        // --- asynchronous reset while LOCKED with a write pending ---
        wv[0] = 1; wd[0] = 32'h00; wm[0] = 32'hFF;
        #3;
        resetb = 1'b0;
        model_reset();
        #1;
        chk("midrst out8", {24'h0, out8}, 32'hA5);
        chk("midrst locked", 32'(lck[0]), 32'd0);
        chk("midrst released", 32'(rel[0]), 32'd0);
        check_all();
        repeat (2) @(posedge clk);
        #1;
        chk("midrst held out8", {24'h0, out8}, 32'hA5);
        @(negedge clk);
        resetb = 1'b1;
        idle_all();
        for (int e = 1; e <= 16; e++) begin
            step();
            chk($sformatf("rerel8 e%0d", e), 32'(rel[0]), (e >= 16) ? 32'd1 : 32'd0);
        end
        wv[0] = 1; wd[0] = 32'h3C; wm[0] = 32'hFF;
        step();
        chk("post-reset write", {24'h0, out8}, 32'h3C);

        // --- randomized traffic against the model ---
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) begin
                @(negedge clk);
                #2;
                resetb = 1'b0;
                model_reset();
                #1;
                check_all();
                @(negedge clk);
                resetb = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                wv[i] = 1'($urandom_range(0, 1));
                wd[i] = $urandom();
                wm[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
                lk[i] = ($urandom_range(0, 99) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/constant_bank.md
# constant_bank

Parametrised constant-tie generator for the 1.8V domain. Drives NCH registered constant lines plus fixed `one`/`zero` ties, and holds every programmable line at a safe default until a post-reset settle interval has elapsed. After release, firmware can rewrite the lines through a masked write handshake until a sticky lock freezes them until the next reset. It sits beside the housekeeping logic and feeds tie-off and default-select inputs of the user-area and I/O control blocks.

## Interface
Parameters:
- NCH, 8, number of programmable constant channels (1..32)
- DEFAULT_VAL, {NCH{1'b0}}, NCH-bit value driven on `const_out` during reset and hold
- RELEASE_CYCLES, 16, clock edges after reset deassertion before release (must be >= 1)

Ports (clock and reset first):
- clk, input, 1, block clock
- resetb, input, 1, asynchronous active-low reset (one clock; reset asynchronous, active-low)
- wr_valid, input, 1, write request
- wr_ready, output, 1, write accept; high only in ACTIVE
- wr_data, input, NCH, new channel values
- wr_mask, input, NCH, per-bit write enable (1 = update bit)
- lock, input, 1, lock request, sampled in ACTIVE only
- released, output, 1, settle interval complete
- locked, output, 1, sticky lock status
- const_out, output, NCH, registered constant lines
- one, output, 1, constant 1'b1, independent of clock and reset
- zero, output, 1, constant 1'b0, independent of clock and reset

## Operation
- States: HOLD, ACTIVE, LOCKED. Reset forces HOLD asynchronously.
- Reset values: `const_out` = DEFAULT_VAL, `released` = 0, `locked` = 0, `wr_ready` = 0, settle counter = 0.
- HOLD: the counter (width $clog2(RELEASE_CYCLES+1)) increments on each rising edge. On the edge where it reaches RELEASE_CYCLES, go to ACTIVE with `released` = 1. The counter saturates and never wraps. `wr_valid` and `lock` are ignored.
- ACTIVE: `wr_ready` = 1 (combinational from state).
  - A write transfers when `wr_valid && wr_ready`.
  - On that edge: `const_out <= (const_out & ~wr_mask) | (wr_data & wr_mask)`.
  - A write with `wr_mask` = 0 transfers and leaves `const_out` unchanged.
- `lock` high in ACTIVE: go to LOCKED on that edge and set `locked` = 1.
- Write and lock in the same cycle: the write is applied on that edge, then the state is LOCKED.
- LOCKED: `wr_ready` = 0. `const_out` is frozen. `locked` and `released` stay 1 until `resetb` is asserted. Further `lock` or `wr_valid` has no effect.
- `one` and `zero` are pure ties with no state dependence, and are valid during reset.
- The `wr_data` and `wr_mask` values are don't-care whenever no transfer occurs.

## Timing
- All state and outputs except `one`, `zero` and `wr_ready` are registered on the rising edge of `clk`.
- `wr_ready` is derived from the state register only. It has no combinational path from any input.
- Release latency: `released` rises after exactly RELEASE_CYCLES rising edges following `resetb` deassertion. The first edge after deassertion counts as 1.
- Write latency: `const_out` updates 1 cycle after the transfer cycle. Back-to-back writes are accepted every cycle.
- Lock latency: `wr_ready` falls and `locked` rises 1 cycle after `lock` is sampled.
- Reset mid-operation, in any state: asynchronously return `const_out` to DEFAULT_VAL and clear `released` and `locked`. A write pending in that cycle is discarded. The settle interval restarts from 0 after deassertion.
- `const_out` never glitches: each bit changes only on a clock edge or on reset assertion.

## Test plan
- Reset/release with NCH=8, DEFAULT_VAL=8'hA5, RELEASE_CYCLES=16.
  - Hold `resetb` low, then release it -> `const_out` = 8'hA5 throughout and `one`/`zero` = 1/0 during reset.
  - `released`/`wr_ready` low for edges 1..15 and high after edge 16.
  - `wr_valid` with data 8'hFF during HOLD -> no change.
- Masked write: from `const_out` = 8'hA5, write data 8'h0F with mask 8'h3C -> `const_out` = 8'h8D the next cycle.
  - Then a write with mask 8'h00 -> remains 8'h8D.
- Back-to-back writes: 3 consecutive cycles with mask 8'hFF and data 8'h01, 8'h02, 8'h03 -> `const_out` follows one cycle behind and ends at 8'h03.
- Simultaneous write+lock: data 8'h55, mask 8'hFF, `lock` = 1 in one cycle -> `const_out` = 8'h55 and `locked` = 1 the next cycle.
  - A subsequent write of 8'hAA -> `wr_ready` = 0 and `const_out` stays 8'h55.
- Reset mid-operation: assert `resetb` low asynchronously (not aligned to `clk`) while LOCKED with a write pending -> immediately `const_out` = 8'hA5 and `locked` = `released` = 0.
  - After deassertion, release again occurs after 16 edges and writes are accepted again.
- Parameter corners: NCH=1 with RELEASE_CYCLES=1 -> `released` rises on the first edge after deassertion and a single-bit masked write works.
  - NCH=32 -> a full-width write of 32'hDEADBEEF reads back exactly.
